// File: rtl/hdmi_timing_pkg.sv
// Shared constants for the HDMI timing controller: mode tables, FSM encoding,
// counter width and a small region-decode helper.
package hdmi_timing_pkg;

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned MAX_TOTAL = 2047;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 800x600 @ 60 Hz
    localparam int unsigned M60_HAPIX = 800;
    localparam int unsigned M60_HFPOR = 40;
    localparam int unsigned M60_HSPUL = 128;
    localparam int unsigned M60_HBPOR = 88;
    localparam int unsigned M60_VAPIX = 600;
    localparam int unsigned M60_VFPOR = 1;
    localparam int unsigned M60_VSPUL = 4;
    localparam int unsigned M60_VBPOR = 23;

    // 800x600 @ 120 Hz (reduced blanking)
    localparam int unsigned M120_HAPIX = 800;
    localparam int unsigned M120_HFPOR = 48;
    localparam int unsigned M120_HSPUL = 32;
    localparam int unsigned M120_HBPOR = 80;
    localparam int unsigned M120_VAPIX = 600;
    localparam int unsigned M120_VFPOR = 3;
    localparam int unsigned M120_VSPUL = 4;
    localparam int unsigned M120_VBPOR = 29;

    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/hdmi_timing_axis.sv
// One timing axis: wrap counter with advance/clear, region flags for the
// current position and an active-region lookahead for the next position.
module hdmi_timing_axis
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = M60_HAPIX,
    parameter int unsigned FPOR   = M60_HFPOR,
    parameter int unsigned SPUL   = M60_HSPUL,
    parameter int unsigned BPOR   = M60_HBPOR
) (
    input  logic             i_clk,
    input  logic             i_advance,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_active,
    output logic             o_sync,
    output logic             o_next_active
);

    localparam int unsigned TOTAL = ACTIVE + FPOR + SPUL + BPOR;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FPOR);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FPOR + SPUL);

    generate
        if (ACTIVE == 0 || FPOR == 0 || SPUL == 0 || BPOR == 0 || TOTAL > MAX_TOTAL) begin : g_bad_params
            $error("hdmi_timing_axis: zero width or total %0d above %0d", TOTAL, MAX_TOTAL);
        end
    endgenerate

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;
    logic             w_at_last;

    // Clear wins over advance so reset and IDLE always park the counter at 0.
    always_comb begin
        w_at_last = (r_count == LAST);
        w_next    = r_count;
        if (i_clear) begin
            w_next = '0;
        end else if (i_advance) begin
            w_next = w_at_last ? '0 : r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        r_count <= w_next;
    end

    assign o_count       = r_count;
    assign o_wrap        = i_advance & w_at_last & ~i_clear;
    assign o_active      = (r_count < ACT_END);
    assign o_sync        = in_window(r_count, SYNC_BEG, SYNC_END);
    assign o_next_active = (w_next < ACT_END);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing controller for the TMDS transmitter: registered syncs, DE,
// coordinates and a one-cycle-early pixel request; starts/stops on frame edges.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned HAPIX     = M60_HAPIX,
    parameter int unsigned HFPOR     = M60_HFPOR,
    parameter int unsigned HSPUL     = M60_HSPUL,
    parameter int unsigned HBPOR     = M60_HBPOR,
    parameter int unsigned VAPIX     = M60_VAPIX,
    parameter int unsigned VFPOR     = M60_VFPOR,
    parameter int unsigned VSPUL     = M60_VSPUL,
    parameter int unsigned VBPOR     = M60_VBPOR,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic             clock_pixel,
    input  logic             iReset,
    input  logic             iEnable,
    output logic             SYNC_H,
    output logic             SYNC_V,
    output logic             DE,
    output logic             oRequest,
    output logic [CNT_W-1:0] oX,
    output logic [CNT_W-1:0] oY,
    output logic             oFrameStart,
    output logic             oBusy
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_run;
    logic             w_clear;
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_h_next_active;
    logic             w_v_next_active;
    logic             w_de_now;

    logic             r_de;
    logic             r_req;
    logic             r_fs;
    logic             r_sync_h;
    logic             r_sync_v;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;

    hdmi_timing_axis #(
        .ACTIVE(HAPIX), .FPOR(HFPOR), .SPUL(HSPUL), .BPOR(HBPOR)
    ) u_h_axis (
        .i_clk         (clock_pixel),
        .i_advance     (w_run),
        .i_clear       (w_clear),
        .o_count       (w_h),
        .o_wrap        (w_h_wrap),
        .o_active      (w_h_active),
        .o_sync        (w_h_sync),
        .o_next_active (w_h_next_active)
    );

    hdmi_timing_axis #(
        .ACTIVE(VAPIX), .FPOR(VFPOR), .SPUL(VSPUL), .BPOR(VBPOR)
    ) u_v_axis (
        .i_clk         (clock_pixel),
        .i_advance     (w_h_wrap),
        .i_clear       (w_clear),
        .o_count       (w_v),
        .o_wrap        (w_v_wrap),
        .o_active      (w_v_active),
        .o_sync        (w_v_sync),
        .o_next_active (w_v_next_active)
    );

    always_ff @(posedge clock_pixel) begin
        if (iReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving RUN is only possible on the last position of a frame.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (iEnable) w_state_next = RUN;
            RUN:     if (w_v_wrap && !iEnable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_run   = (r_state == RUN);
        w_clear = iReset | ~w_run;
        oBusy   = w_run;
    end

    assign w_de_now = w_run & w_h_active & w_v_active;

    always_ff @(posedge clock_pixel) begin
        if (iReset) begin
            r_de     <= 1'b0;
            r_req    <= 1'b0;
            r_fs     <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_sync_h <= ~HSYNC_POL;
            r_sync_v <= ~VSYNC_POL;
        end else begin
            r_de     <= w_de_now;
            // Request looks at the position the counters move to on this edge.
            r_req    <= (w_state_next == RUN) & w_h_next_active & w_v_next_active;
            r_fs     <= w_de_now & (w_h == '0) & (w_v == '0);
            r_x      <= w_de_now ? w_h : '0;
            r_y      <= w_de_now ? w_v : '0;
            r_sync_h <= ~((w_run & w_h_sync) ^ HSYNC_POL);
            r_sync_v <= ~((w_run & w_v_sync) ^ VSYNC_POL);
        end
    end

    assign DE          = r_de;
    assign oRequest    = r_req;
    assign oFrameStart = r_fs;
    assign oX          = r_x;
    assign oY          = r_y;
    assign SYNC_H      = r_sync_h;
    assign SYNC_V      = r_sync_v;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl on a shrunken mode, one instance per sync polarity,
// with a frame-position reference model and literal timing checks.
module tb_hdmi_timing_ctrl;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;

    logic        p_sh, p_sv, p_de, p_req, p_fs, p_busy;
    logic [10:0] p_x, p_y;
    logic        n_sh, n_sv, n_de, n_req, n_fs, n_busy;
    logic [10:0] n_x, n_y;

    always #5 clk = ~clk;

    hdmi_timing_ctrl #(
        .HAPIX(HA), .HFPOR(HF), .HSPUL(HS), .HBPOR(HB),
        .VAPIX(VA), .VFPOR(VF), .VSPUL(VS), .VBPOR(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_p (
        .clock_pixel(clk), .iReset(rst), .iEnable(en),
        .SYNC_H(p_sh), .SYNC_V(p_sv), .DE(p_de), .oRequest(p_req),
        .oX(p_x), .oY(p_y), .oFrameStart(p_fs), .oBusy(p_busy)
    );

    hdmi_timing_ctrl #(
        .HAPIX(HA), .HFPOR(HF), .HSPUL(HS), .HBPOR(HB),
        .VAPIX(VA), .VFPOR(VF), .VSPUL(VS), .VBPOR(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_n (
        .clock_pixel(clk), .iReset(rst), .iEnable(en),
        .SYNC_H(n_sh), .SYNC_V(n_sv), .DE(n_de), .oRequest(n_req),
        .oX(n_x), .oY(n_y), .oFrameStart(n_fs), .oBusy(n_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a running flag and a linear position within the frame.
    function automatic int pos_de(input int run, input int p);
        return (run != 0 && (p % HT) < HA && (p / HT) < VA) ? 1 : 0;
    endfunction

    function automatic int pos_hs(input int run, input int p);
        return (run != 0 && (p % HT) >= HA + HF && (p % HT) < HA + HF + HS) ? 1 : 0;
    endfunction

    function automatic int pos_vs(input int run, input int p);
        return (run != 0 && (p / HT) >= VA + VF && (p / HT) < VA + VF + VS) ? 1 : 0;
    endfunction

    function automatic int next_run(input int run, input int p, input int e);
        if (run == 0) return e;
        if (p == FT - 1 && e == 0) return 0;
        return 1;
    endfunction

    function automatic int next_p(input int run, input int p, input int e);
        if (next_run(run, p, e) == 0 || run == 0) return 0;
        return (p + 1) % FT;
    endfunction

    int m_run = 0, m_p = 0;
    int e_de = 0, e_req = 0, e_hs = 0, e_vs = 0, e_fs = 0, e_x = 0, e_y = 0, e_busy = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 0; m_p <= 0;
            e_de <= 0; e_req <= 0; e_hs <= 0; e_vs <= 0; e_fs <= 0;
            e_x <= 0; e_y <= 0; e_busy <= 0;
        end else begin
            e_de   <= pos_de(m_run, m_p);
            e_hs   <= pos_hs(m_run, m_p);
            e_vs   <= pos_vs(m_run, m_p);
            e_fs   <= (m_run != 0 && m_p == 0) ? 1 : 0;
            e_x    <= pos_de(m_run, m_p) != 0 ? m_p % HT : 0;
            e_y    <= pos_de(m_run, m_p) != 0 ? m_p / HT : 0;
            e_req  <= pos_de(next_run(m_run, m_p, int'(en)), next_p(m_run, m_p, int'(en)));
            e_busy <= next_run(m_run, m_p, int'(en));
            m_run  <= next_run(m_run, m_p, int'(en));
            m_p    <= next_p(m_run, m_p, int'(en));
        end
        chk_on <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("de",     int'(p_de),   e_de);
            check("req",    int'(p_req),  e_req);
            check("fs",     int'(p_fs),   e_fs);
            check("busy",   int'(p_busy), e_busy);
            check("x",      int'(p_x),    e_x);
            check("y",      int'(p_y),    e_y);
            check("sh_pos", int'(p_sh),   e_hs);
            check("sv_pos", int'(p_sv),   e_vs);
            check("sh_neg", int'(n_sh),   1 - e_hs);
            check("sv_neg", int'(n_sv),   1 - e_vs);
            check("n_de",   int'(n_de),   e_de);
            check("n_req",  int'(n_req),  e_req);
            check("n_fs",   int'(n_fs),   e_fs);
            check("n_busy", int'(n_busy), e_busy);
            check("n_xy",   int'({n_x, n_y}), (e_x << 11) | e_y);
        end
    end

    int de_c, req_c, sh_c, sv_c, fs_c, line_de, first_sh, first_sv, k, min_busy;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle with enable low
        repeat (20) @(negedge clk);
        check("idle_de",     int'(p_de),   0);
        check("idle_req",    int'(p_req),  0);
        check("idle_busy",   int'(p_busy), 0);
        check("idle_sh_pos", int'(p_sh),   0);
        check("idle_sv_pos", int'(p_sv),   0);
        check("idle_sh_neg", int'(n_sh),   1);
        check("idle_sv_neg", int'(n_sv),   1);

        // Start latency
        en = 1'b1;
        @(negedge clk);
        check("start_req",  int'(p_req),  1);
        check("start_de0",  int'(p_de),   0);
        check("start_busy", int'(p_busy), 1);
        @(negedge clk);
        check("start_de",   int'(p_de), 1);
        check("start_fs",   int'(p_fs), 1);
        check("start_x",    int'(p_x),  0);
        check("start_y",    int'(p_y),  0);

        // One full frame measured from the first DE cycle
        de_c = 0; req_c = 0; sh_c = 0; sv_c = 0; fs_c = 0; line_de = 0;
        first_sh = -1; first_sv = -1;
        for (int i = 0; i < FT; i++) begin
            de_c  += int'(p_de);
            req_c += int'(p_req);
            sh_c  += int'(p_sh);
            sv_c  += int'(p_sv);
            fs_c  += int'(p_fs);
            if (i < HT) line_de += int'(p_de);
            if (i < HA) check("line_x", int'(p_x), i);
            if (p_sh && first_sh < 0) first_sh = i;
            if (p_sv && first_sv < 0) first_sv = i;
            @(negedge clk);
        end
        check("line_de_len",   line_de,  HA);
        check("frame_de",      de_c,     HA * VA);
        check("frame_req",     req_c,    HA * VA);
        check("frame_sh",      sh_c,     HS * VT);
        check("frame_sv",      sv_c,     VS * HT);
        check("frame_fs",      fs_c,     1);
        check("sh_offset",     first_sh, HA + HF);
        check("sv_offset",     first_sv, (VA + VF) * HT);
        check("frame_period",  int'(p_fs), 1);

        // Drop enable on line 2; the frame must finish
        repeat (2 * HT) @(negedge clk);
        en = 1'b0;
        k = 2 * HT;
        while (p_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("stop_cycle", k, FT - 1);
        de_c = 0;
        for (int i = 0; i < 30; i++) begin
            de_c += int'(p_de);
            @(negedge clk);
        end
        check("after_stop_de",   de_c,         0);
        check("after_stop_busy", int'(p_busy), 0);

        // Restart, drop and reassert mid-frame: frames stay contiguous
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_fs", int'(p_fs), 1);
        fs_c = 0; de_c = 0; min_busy = 1;
        for (int i = 0; i < 2 * FT; i++) begin
            if (i == 2 * HT) en = 1'b0;
            if (i == 2 * HT + 10) en = 1'b1;
            fs_c += int'(p_fs);
            de_c += int'(p_de);
            if (!p_busy) min_busy = 0;
            @(negedge clk);
        end
        check("contig_fs",   fs_c,     2);
        check("contig_de",   de_c,     2 * HA * VA);
        check("contig_busy", min_busy, 1);

        // Reset in the middle of both sync regions
        repeat ((VA + VF) * HT + HA + HF + 1) @(negedge clk);
        check("pre_rst_sh_neg", int'(n_sh), 0);
        check("pre_rst_sv_neg", int'(n_sv), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_sh_neg", int'(n_sh),   1);
        check("rst_sv_neg", int'(n_sv),   1);
        check("rst_sh_pos", int'(p_sh),   0);
        check("rst_de",     int'(p_de),   0);
        check("rst_req",    int'(p_req),  0);
        check("rst_busy",   int'(n_busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rerun_req", int'(n_req), 1);
        @(negedge clk);
        check("rerun_de",  int'(n_de), 1);
        check("rerun_fs",  int'(n_fs), 1);
        check("rerun_xy",  int'({n_x, n_y}), 0);

        // Randomized enable toggling with occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        en  = 1'b0;
        repeat (200) @(negedge clk);
        check("final_busy", int'(p_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
